// File: rtl/video_pkg.sv
// Shared constants and pixel helpers for the 640x480@60 display path and the
// dual-camera fetch stage that sits behind the timing generator.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int SRC_W = 320;
  localparam int SRC_H = 240;

  // Color bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam int BAR_W = 80;
  localparam logic [0:7][23:0] BAR_LUT = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // x / BAR_W without a divider: count the bar boundaries already passed.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * BAR_W)) idx = idx + 3'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that keeps sync/enable strobes aligned with a
// pipelined data path; every stage resets to RST_VAL.
module sync_delay_line #(
  parameter int              DEPTH   = 3,
  parameter int              WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dual_cam_pixel_fetch.sv
// Fetches two 320x240 RGB565 camera frames side by side with line doubling and
// emits RGB888 aligned with delayed h_sync/v_sync/de (3-cycle latency).
module dual_cam_pixel_fetch #(
  parameter int SRC_W   = video_pkg::SRC_W,
  parameter int SRC_H   = video_pkg::SRC_H,
  parameter int ADDR_W  = 17,
  parameter int RAM_LAT = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  input  logic              de_i,
  input  logic [9:0]        x_pixel_i,
  input  logic [9:0]        y_pixel_i,
  input  logic              pattern_en,
  input  logic              cam0_bank_rdy,
  input  logic              cam1_bank_rdy,
  output logic              cam0_rd_en,
  output logic              cam0_rd_bank,
  output logic [ADDR_W-1:0] cam0_rd_addr,
  input  logic [15:0]       cam0_rd_data,
  output logic              cam1_rd_en,
  output logic              cam1_rd_bank,
  output logic [ADDR_W-1:0] cam1_rd_addr,
  input  logic [15:0]       cam1_rd_data,
  output logic              frame_start,
  output logic              h_sync_o,
  output logic              v_sync_o,
  output logic              de_o,
  output logic [7:0]        r_o,
  output logic [7:0]        g_o,
  output logic [7:0]        b_o
);

  import video_pkg::*;

  if (RAM_LAT != 1) begin : g_bad_ram_lat
    $error("dual_cam_pixel_fetch: only RAM_LAT = 1 is supported");
  end
  if ((1 << ADDR_W) < SRC_W * SRC_H) begin : g_bad_addr_w
    $error("dual_cam_pixel_fetch: ADDR_W too small for SRC_W*SRC_H");
  end

  logic              vs_prev, rst_q, vs_fall, run_en;
  logic              bank0_q, bank1_q, pattern_q;
  logic              sel, in_area, vld, rd_req;
  logic [9:0]        col;
  logic [8:0]        row;
  logic [ADDR_W-1:0] addr_nxt;
  logic              sel_s0, vld_s0, pat_s0, sel_s1, vld_s1, pat_s1;
  logic [2:0]        bar_s0, bar_s1;
  logic [2:0]        sync_dly;

  // An edge seen on the first cycle out of reset is dropped along with anything inside reset.
  assign vs_fall = vs_prev && !v_sync_i && !rst_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_prev     <= 1'b1;
      rst_q       <= 1'b1;
      run_en      <= 1'b0;
      frame_start <= 1'b0;
      bank0_q     <= 1'b0;
      bank1_q     <= 1'b0;
      pattern_q   <= 1'b0;
    end else begin
      vs_prev     <= v_sync_i;
      rst_q       <= 1'b0;
      frame_start <= vs_fall;
      if (vs_fall) begin
        bank0_q   <= cam0_bank_rdy;
        bank1_q   <= cam1_bank_rdy;
        pattern_q <= pattern_en;
        run_en    <= 1'b1;
      end
    end
  end

  assign cam0_rd_bank = bank0_q;
  assign cam1_rd_bank = bank1_q;

  // row*320 + col as shifts, so no multiplier is inferred.
  assign sel      = (x_pixel_i >= 10'(SRC_W));
  assign col      = sel ? (x_pixel_i - 10'(SRC_W)) : x_pixel_i;
  assign row      = y_pixel_i[9:1];
  assign addr_nxt = ADDR_W'({row, 8'b0}) + ADDR_W'({row, 6'b0}) + ADDR_W'(col);
  assign in_area  = (x_pixel_i < 10'(2 * SRC_W)) && (y_pixel_i < 10'(2 * SRC_H));
  assign vld      = de_i && in_area && run_en;
  assign rd_req   = vld && !pattern_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      cam0_rd_en   <= 1'b0;
      cam1_rd_en   <= 1'b0;
      cam0_rd_addr <= '0;
      cam1_rd_addr <= '0;
      sel_s0       <= 1'b0;
      vld_s0       <= 1'b0;
      pat_s0       <= 1'b0;
      bar_s0       <= '0;
    end else begin
      cam0_rd_en <= rd_req && !sel;
      cam1_rd_en <= rd_req && sel;
      if (rd_req && !sel) cam0_rd_addr <= addr_nxt;
      if (rd_req && sel)  cam1_rd_addr <= addr_nxt;
      sel_s0 <= sel;
      vld_s0 <= vld;
      pat_s0 <= pattern_q;
      bar_s0 <= bar_index(x_pixel_i);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sel_s1            <= 1'b0;
      vld_s1            <= 1'b0;
      pat_s1            <= 1'b0;
      bar_s1            <= '0;
      {r_o, g_o, b_o}   <= '0;
    end else begin
      sel_s1 <= sel_s0;
      vld_s1 <= vld_s0;
      pat_s1 <= pat_s0;
      bar_s1 <= bar_s0;
      if (!vld_s1)     {r_o, g_o, b_o} <= '0;
      else if (pat_s1) {r_o, g_o, b_o} <= BAR_LUT[bar_s1];
      else             {r_o, g_o, b_o} <= rgb565_to_888(sel_s1 ? cam1_rd_data : cam0_rd_data);
    end
  end

  sync_delay_line #(
    .DEPTH   (3),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .pclk (pclk),
    .rst  (rst),
    .din  ({h_sync_i, v_sync_i, de_i}),
    .dout (sync_dly)
  );

  assign {h_sync_o, v_sync_o, de_o} = sync_dly;

endmodule

// File: tb/tb_dual_cam_pixel_fetch.sv
// Directed bench for dual_cam_pixel_fetch: reset, address mapping, colour
// expansion, bank latching, colour-bar mode and blanking/sync alignment.
module tb_dual_cam_pixel_fetch;

  import video_pkg::*;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        h_sync_i = 1'b1, v_sync_i = 1'b1, de_i = 1'b0;
  logic [9:0]  x_pixel_i = '0, y_pixel_i = '0;
  logic        pattern_en = 1'b0, cam0_bank_rdy = 1'b0, cam1_bank_rdy = 1'b0;
  logic        cam0_rd_en, cam0_rd_bank, cam1_rd_en, cam1_rd_bank;
  logic [16:0] cam0_rd_addr, cam1_rd_addr;
  logic [15:0] cam0_rd_data = '0, cam1_rd_data = '0;
  logic        frame_start, h_sync_o, v_sync_o, de_o;
  logic [7:0]  r_o, g_o, b_o;
  logic [23:0] rgb;

  int checks = 0;
  int passes = 0;

  dual_cam_pixel_fetch dut (
    .pclk(pclk), .rst(rst),
    .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .de_i(de_i),
    .x_pixel_i(x_pixel_i), .y_pixel_i(y_pixel_i),
    .pattern_en(pattern_en),
    .cam0_bank_rdy(cam0_bank_rdy), .cam1_bank_rdy(cam1_bank_rdy),
    .cam0_rd_en(cam0_rd_en), .cam0_rd_bank(cam0_rd_bank),
    .cam0_rd_addr(cam0_rd_addr), .cam0_rd_data(cam0_rd_data),
    .cam1_rd_en(cam1_rd_en), .cam1_rd_bank(cam1_rd_bank),
    .cam1_rd_addr(cam1_rd_addr), .cam1_rd_data(cam1_rd_data),
    .frame_start(frame_start),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .de_o(de_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );

  assign rgb = {r_o, g_o, b_o};

  always #5 pclk = ~pclk;

  // One-cycle-latency frame buffers: cam0 returns its address (pure red at 0), cam1 its inverse.
  always @(posedge pclk) begin
    if (cam0_rd_en) cam0_rd_data <= (cam0_rd_addr == 17'd0) ? 16'hF800 : cam0_rd_addr[15:0];
    if (cam1_rd_en) cam1_rd_data <= ~cam1_rd_addr[15:0];
  end

  task automatic step(input int x, input int y);
    x_pixel_i = 10'(x);
    y_pixel_i = 10'(y);
    de_i      = (x < H_ACTIVE) && (y < V_ACTIVE);
    h_sync_i  = !((x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC));
    v_sync_i  = !((y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC));
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    logic rd_seen;
    rst = 1'b1;
    step(100, 100);
    step(101, 100);
    checks++; if ({h_sync_o, v_sync_o, de_o} !== 3'b110) $display("[TB] FAIL reset_sync: got %b expected 110", {h_sync_o, v_sync_o, de_o}); else passes++;
    checks++; if (rgb !== 24'h0) $display("[TB] FAIL reset_rgb: got %h expected 000000", rgb); else passes++;
    checks++; if ({cam0_rd_en, cam1_rd_en, cam0_rd_bank, cam1_rd_bank, frame_start} !== 5'b0) $display("[TB] FAIL reset_ctrl: got %b expected 00000", {cam0_rd_en, cam1_rd_en, cam0_rd_bank, cam1_rd_bank, frame_start}); else passes++;
    checks++; if ({cam0_rd_addr, cam1_rd_addr} !== 34'h0) $display("[TB] FAIL reset_addr: got %0d/%0d expected 0/0", cam0_rd_addr, cam1_rd_addr); else passes++;
    rst = 1'b0;
    rd_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(102 + i, 100);
      rd_seen = rd_seen | cam0_rd_en | cam1_rd_en;
    end
    checks++; if (rd_seen !== 1'b0) $display("[TB] FAIL no_read_before_frame: got %b expected 0", rd_seen); else passes++;
    checks++; if ({de_o, rgb} !== {1'b1, 24'h0}) $display("[TB] FAIL dark_before_frame: got de=%b rgb=%h expected de=1 rgb=000000", de_o, rgb); else passes++;
    step(0, 489);
    checks++; if (frame_start !== 1'b0) $display("[TB] FAIL frame_start_early: got %b expected 0", frame_start); else passes++;
    step(0, 490);
    checks++; if (frame_start !== 1'b1) $display("[TB] FAIL frame_start_pulse: got %b expected 1", frame_start); else passes++;
    step(0, 491);
    checks++; if (frame_start !== 1'b0) $display("[TB] FAIL frame_start_width: got %b expected 0", frame_start); else passes++;
  endtask

  task automatic test_address_map();
    step(5, 10);
    checks++; if ({cam0_rd_en, cam1_rd_en} !== 2'b10) $display("[TB] FAIL left_en: got %b expected 10", {cam0_rd_en, cam1_rd_en}); else passes++;
    checks++; if (cam0_rd_addr !== 17'd1605) $display("[TB] FAIL left_addr: got %0d expected 1605", cam0_rd_addr); else passes++;
    step(325, 10);
    checks++; if ({cam0_rd_en, cam1_rd_en} !== 2'b01) $display("[TB] FAIL right_en: got %b expected 01", {cam0_rd_en, cam1_rd_en}); else passes++;
    checks++; if (cam1_rd_addr !== 17'd1605) $display("[TB] FAIL right_addr: got %0d expected 1605", cam1_rd_addr); else passes++;
    checks++; if (cam0_rd_addr !== 17'd1605) $display("[TB] FAIL left_addr_hold: got %0d expected 1605", cam0_rd_addr); else passes++;
    step(6, 10);
    checks++; if (rgb !== 24'h00CB29) $display("[TB] FAIL left_rgb: got %h expected 00CB29", rgb); else passes++;
    step(7, 10);
    checks++; if (rgb !== 24'hFF34D6) $display("[TB] FAIL right_rgb: got %h expected FF34D6", rgb); else passes++;
    step(319, 0);
    checks++; if ({cam0_rd_en, cam0_rd_addr} !== {1'b1, 17'd319}) $display("[TB] FAIL x319: got en=%b addr=%0d expected en=1 addr=319", cam0_rd_en, cam0_rd_addr); else passes++;
    step(320, 0);
    checks++; if ({cam1_rd_en, cam1_rd_addr} !== {1'b1, 17'd0}) $display("[TB] FAIL x320: got en=%b addr=%0d expected en=1 addr=0", cam1_rd_en, cam1_rd_addr); else passes++;
    step(639, 479);
    checks++; if (cam1_rd_addr !== 17'd76799) $display("[TB] FAIL last_addr: got %0d expected 76799", cam1_rd_addr); else passes++;
    step(0, 479);
    checks++; if (cam0_rd_addr !== 17'd76480) $display("[TB] FAIL last_row_left: got %0d expected 76480", cam0_rd_addr); else passes++;
  endtask

  task automatic test_red_pixel();
    step(798, 524);
    step(799, 524);
    checks++; if ({cam0_rd_en, cam1_rd_en} !== 2'b00) $display("[TB] FAIL vblank_no_read: got %b expected 00", {cam0_rd_en, cam1_rd_en}); else passes++;
    step(0, 0);
    checks++; if (de_o !== 1'b0) $display("[TB] FAIL de_lat_1: got %b expected 0", de_o); else passes++;
    step(1, 0);
    checks++; if (de_o !== 1'b0) $display("[TB] FAIL de_lat_2: got %b expected 0", de_o); else passes++;
    step(2, 0);
    checks++; if (de_o !== 1'b1) $display("[TB] FAIL de_lat_3: got %b expected 1", de_o); else passes++;
    checks++; if (rgb !== 24'hFF0000) $display("[TB] FAIL red_pixel: got %h expected FF0000", rgb); else passes++;
  endtask

  task automatic test_bank_switch();
    step(325, 100);
    cam1_bank_rdy = 1'b1;
    step(326, 100);
    step(327, 100);
    checks++; if (cam1_rd_bank !== 1'b0) $display("[TB] FAIL bank_mid_frame: got %b expected 0", cam1_rd_bank); else passes++;
    step(0, 489);
    checks++; if (cam1_rd_bank !== 1'b0) $display("[TB] FAIL bank_before_edge: got %b expected 0", cam1_rd_bank); else passes++;
    step(0, 490);
    checks++; if ({frame_start, cam0_rd_bank, cam1_rd_bank} !== 3'b101) $display("[TB] FAIL bank_latched: got %b expected 101", {frame_start, cam0_rd_bank, cam1_rd_bank}); else passes++;
    cam1_bank_rdy = 1'b0;
    step(10, 20);
    step(11, 20);
    checks++; if (cam1_rd_bank !== 1'b1) $display("[TB] FAIL bank_hold: got %b expected 1", cam1_rd_bank); else passes++;
  endtask

  task automatic test_pattern();
    logic [23:0] bars [8];
    logic        rd_seen;
    int          px;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    pattern_en = 1'b1;
    step(0, 489);
    step(0, 490);
    pattern_en = 1'b0;
    rd_seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      step(i, 0);
      rd_seen = rd_seen | cam0_rd_en | cam1_rd_en;
      px = i - 2;
      if (px == 85) begin
        checks++; if (rgb !== 24'hFFFF00) $display("[TB] FAIL bar_x85: got %h expected FFFF00", rgb); else passes++;
      end
      if (px == 639) begin
        checks++; if ({de_o, rgb} !== {1'b1, 24'h0}) $display("[TB] FAIL bar_x639: got de=%b rgb=%h expected de=1 rgb=000000", de_o, rgb); else passes++;
      end
      if (px >= 0 && px < 640 && (px % 80) == 40) begin
        checks++; if (rgb !== bars[px / 80]) $display("[TB] FAIL bar_%0d: got %h expected %h", px / 80, rgb, bars[px / 80]); else passes++;
      end
    end
    checks++; if (rd_seen !== 1'b0) $display("[TB] FAIL pattern_no_read: got %b expected 0", rd_seen); else passes++;
    step(0, 489);
    step(0, 490);
    step(5, 10);
    checks++; if ({cam0_rd_en, cam0_rd_addr} !== {1'b1, 17'd1605}) $display("[TB] FAIL pattern_exit: got en=%b addr=%0d expected en=1 addr=1605", cam0_rd_en, cam0_rd_addr); else passes++;
  endtask

  task automatic test_blanking();
    int mism;
    int lows;
    logic exp_hs;
    step(700, 200);
    checks++; if ({cam0_rd_en, cam1_rd_en} !== 2'b00) $display("[TB] FAIL hblank_no_read: got %b expected 00", {cam0_rd_en, cam1_rd_en}); else passes++;
    step(701, 200);
    step(702, 200);
    checks++; if ({de_o, rgb} !== 25'h0) $display("[TB] FAIL hblank_dark: got de=%b rgb=%h expected de=0 rgb=000000", de_o, rgb); else passes++;
    mism = 0;
    lows = 0;
    for (int x = 600; x < 800; x++) begin
      step(x, 200);
      if (x >= 602) begin
        exp_hs = !((x - 2) >= 656 && (x - 2) <= 751);
        if (h_sync_o !== exp_hs) mism++;
        if (h_sync_o === 1'b0) lows++;
      end
    end
    checks++; if (mism !== 0) $display("[TB] FAIL hsync_align: got %0d misaligned samples expected 0", mism); else passes++;
    checks++; if (lows !== 96) $display("[TB] FAIL hsync_width: got %0d expected 96", lows); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic rd_seen;
    cam0_bank_rdy = 1'b1;
    cam1_bank_rdy = 1'b1;
    step(0, 489);
    step(0, 490);
    checks++; if ({cam0_rd_bank, cam1_rd_bank} !== 2'b11) $display("[TB] FAIL banks_set: got %b expected 11", {cam0_rd_bank, cam1_rd_bank}); else passes++;
    step(50, 30);
    step(51, 30);
    step(52, 30);
    rst = 1'b1;
    step(53, 30);
    checks++; if ({h_sync_o, v_sync_o, de_o, rgb} !== {3'b110, 24'h0}) $display("[TB] FAIL midreset_out: got %b/%h expected 110/000000", {h_sync_o, v_sync_o, de_o}, rgb); else passes++;
    checks++; if ({cam0_rd_en, cam1_rd_en, cam0_rd_bank, cam1_rd_bank} !== 4'b0) $display("[TB] FAIL midreset_ctrl: got %b expected 0000", {cam0_rd_en, cam1_rd_en, cam0_rd_bank, cam1_rd_bank}); else passes++;
    checks++; if ({cam0_rd_addr, cam1_rd_addr} !== 34'h0) $display("[TB] FAIL midreset_addr: got %0d/%0d expected 0/0", cam0_rd_addr, cam1_rd_addr); else passes++;
    rst = 1'b0;
    rd_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(54 + i, 30);
      rd_seen = rd_seen | cam0_rd_en | cam1_rd_en;
    end
    checks++; if ({rd_seen, rgb} !== 25'h0) $display("[TB] FAIL midreset_idle: got rd=%b rgb=%h expected rd=0 rgb=000000", rd_seen, rgb); else passes++;
    rst = 1'b1;
    step(0, 489);
    rst = 1'b0;
    step(0, 490);
    checks++; if (frame_start !== 1'b0) $display("[TB] FAIL edge_at_release: got %b expected 0", frame_start); else passes++;
    step(5, 10);
    checks++; if ({cam0_rd_en, cam1_rd_en} !== 2'b00) $display("[TB] FAIL read_after_release: got %b expected 00", {cam0_rd_en, cam1_rd_en}); else passes++;
    step(0, 489);
    step(0, 490);
    checks++; if ({frame_start, cam0_rd_bank, cam1_rd_bank} !== 3'b111) $display("[TB] FAIL resume_frame: got %b expected 111", {frame_start, cam0_rd_bank, cam1_rd_bank}); else passes++;
    step(5, 10);
    checks++; if ({cam0_rd_en, cam1_rd_en} !== 2'b10) $display("[TB] FAIL resume_read: got %b expected 10", {cam0_rd_en, cam1_rd_en}); else passes++;
  endtask

  initial begin
    $display("[TB] starting dual_cam_pixel_fetch bench");
    test_reset();
    test_address_map();
    test_red_pixel();
    test_bank_switch();
    test_pattern();
    test_blanking();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dual_cam_pixel_fetch.md
Name: dual_cam_pixel_fetch

Overview:
- Sits directly downstream of the 640x480@60 timing generator.
- Consumes its h_sync, v_sync, DE, x_pixel and y_pixel, and issues synchronous read requests to two camera frame buffers (cam0 and cam1, each 320x240 RGB565, double-banked).
- Produces side-by-side video: cam0 on the left half, cam1 on the right half, each line doubled vertically.
- Outputs RGB888 with h_sync, v_sync and DE delayed to stay aligned with the pixel data.

Parameters:
- SRC_W, 320, source frame width in pixels.
- SRC_H, 240, source frame height in pixels.
- ADDR_W, 17, frame-buffer word address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H.
- RAM_LAT, 1, frame-buffer read latency in cycles. Only 1 is supported; any other value is a elaboration error.

Ports:
- pclk  in  1  pixel clock. All logic samples on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- h_sync_i  in  1  timing hsync, active-low.
- v_sync_i  in  1  timing vsync, active-low.
- de_i  in  1  timing data enable.
- x_pixel_i  in  10  horizontal counter, 0..799.
- y_pixel_i  in  10  vertical counter, 0..524.
- pattern_en  in  1  color-bar test mode request.
- cam0_bank_rdy  in  1  bank of cam0 most recently completed by the writer.
- cam1_bank_rdy  in  1  bank of cam1 most recently completed by the writer.
- cam0_rd_en  out  1  cam0 read strobe.
- cam0_rd_bank  out  1  cam0 bank to read.
- cam0_rd_addr  out  ADDR_W  cam0 word address.
- cam0_rd_data  in  16  cam0 RGB565, valid RAM_LAT cycles after the strobe.
- cam1_rd_en, cam1_rd_bank, cam1_rd_addr, cam1_rd_data: same as the cam0 ports, for cam1.
- frame_start  out  1  one-cycle pulse when the display banks are latched.
- h_sync_o  out  1  delayed hsync.
- v_sync_o  out  1  delayed vsync.
- de_o  out  1  delayed data enable.
- r_o, g_o, b_o  out  8 each  pixel color.

Behaviour:
- Reset values:
  - h_sync_o=1, v_sync_o=1, de_o=0, r/g/b=0.
  - cam*_rd_en=0, cam*_rd_addr=0, cam*_rd_bank=0.
  - frame_start=0; latched bank registers=0; latched pattern mode=0.
  - The delay pipeline fills with sync=1, de=0.
  - Reset mid-frame: outputs return to reset values the next cycle. Normal operation resumes at the following frame_start; until then rd_en stays 0 and the RGB outputs stay 0.
- Frame latch:
  - On a falling edge of v_sync_i (previous sample 1, current sample 0), register cam0_bank_rdy, cam1_bank_rdy and pattern_en, and pulse frame_start for one cycle.
  - Display banks are not updated at any other time, which guarantees no tearing.
- Stage 0 (address), one cycle:
  - sel = (x_pixel_i >= SRC_W).
  - col = sel ? x-SRC_W : x.
  - row = y_pixel_i>>1.
  - addr = row*SRC_W + col, computed as (row<<8)+(row<<6)+col with no multiplier, truncated to ADDR_W.
  - rd_en is asserted for the selected camera only, and only when de_i=1, the pattern latch is 0 and the post-reset enable is set.
  - The unselected camera's address register holds its previous value.
- Stage 1 (RAM): read data returns.
- Stage 2 (format):
  - The registered sel picks cam0 or cam1 data.
  - RGB565 expands to RGB888 by bit replication: r = {R5, R5[4:2]}, g = {G6, G6[5:4]}, b = {B5, B5[4:2]}.
  - When the delayed de=0, RGB is 0.
  - When pattern mode is latched, the output is 8 bars of 80 px on x with the (R,G,B) sequence white, yellow, cyan, green, magenta, red, blue, black, each component 8'hFF or 0.
- Latency: 3 cycles from input to output. h_sync, v_sync and de pass through a 3-deep shift register so every output aligns with its pixel.
- Boundaries:
  - x=319 reads cam0 addr row*320+319.
  - x=320 reads cam1 addr row*320+0.
  - y=479 gives row 239 and the final address 76799.
  - x in 640..799 or y in 480..524: no read, RGB 0.
  - If bank_rdy changes during a frame, it is ignored until the next vsync falling edge.
  - A v_sync falling edge that coincides with reset release is ignored.

Decomposition:
- Shared package video_pkg holds:
  - the H/V timing constants shared with the timing generator;
  - SRC_W and SRC_H;
  - the RGB565 to RGB888 expansion function;
  - the color-bar LUT constants.
- One sub-module, sync_delay_line: parameterized depth and width; shifts {h_sync, v_sync, de} with reset values 1/1/0.

Test Plan:
- Reset mid-frame, then release → outputs read 1/1/0/0 immediately; no rd_en until the first frame_start; frame_start is high for exactly 1 cycle after the v_sync falling edge.
- cam0 RAM model returns data=address[15:0], cam1 returns ~address; at y=10, x=5 and x=325 → cam0_rd_addr=1605 and cam1_rd_addr=1605; 3 cycles later the RGB equal the expansions of 16'h0645 and 16'hF9BA.
- cam0 pixel 16'hF800 at address 0 → at output (0,0): r=FF, g=00, b=00; de_o rises exactly 3 cycles after de_i.
- Toggle cam1_bank_rdy at y=100 → cam1_rd_bank stays unchanged until the next frame_start, then follows the new value.
- pattern_en=1 latched → no rd_en for the whole frame; x=85 gives (FF,FF,00); x=639 gives (00,00,00).
- Blanking: x=700, y=200 → rd_en=0 and RGB=0; h_sync_o is low exactly for inputs x=656..751, shifted by 3 cycles.
